// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port A arbiter.
package ram_arb_pkg;
  localparam int ARB_ADDR_W  = 10;
  localparam int ARB_DATA_W  = 8;
  localparam int ARB_MAX_REQ = 8;

  typedef logic [$clog2(ARB_MAX_REQ)-1:0] req_idx_t;

  typedef struct packed {
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } ram_cmd_t;
endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after the last
// accepted grant, wrapping around; pointer moves only on an accepted request.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output req_idx_t           o_idx
);

  req_idx_t r_last;
  logic     w_found;

  // First pass covers requesters above the pointer, second pass the wrap.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i > int'(r_last))) begin
        o_grant[i] = 1'b1;
        o_idx      = req_idx_t'(i);
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i <= int'(r_last))) begin
        o_grant[i] = 1'b1;
        o_idx      = req_idx_t'(i);
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last <= req_idx_t'(NUM_REQ - 1);
    end else if (i_accept) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A among NUM_REQ requesters and routes read data back.
// Optional macro RAM_PORT_ARB_PERF_EN adds per-requester accept counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_W-1:0]              o_rsp_rdata,
  output logic                           o_a_en,
  output logic                           o_a_write_en,
  output logic [ADDR_W-1:0]              o_a_addr,
  output logic [DATA_W-1:0]              o_a_wdata,
  input  logic [DATA_W-1:0]              i_a_rdata
`ifdef RAM_PORT_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]       o_perf_grants
`endif
);

  logic [NUM_REQ-1:0] w_grant;
  req_idx_t           w_idx;
  logic               w_accept;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  ram_cmd_t r_cmd;
  logic     r_a_en;
  logic     r_tag1_valid, r_tag2_valid;
  req_idx_t r_tag1_idx, r_tag2_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_req    (i_req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_accept    = (|w_grant) & ~i_reset;
  assign o_req_ready = i_reset ? '0 : w_grant;

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_write = i_req_write[i];
        w_sel_addr  = i_req_addr[i];
        w_sel_wdata = i_req_wdata[i];
      end
    end
  end

  // Address and data hold on idle cycles; only the enables drop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_a_en <= 1'b0;
      r_cmd  <= '0;
    end else if (w_accept) begin
      r_a_en      <= 1'b1;
      r_cmd.write <= w_sel_write;
      r_cmd.addr  <= w_sel_addr;
      r_cmd.wdata <= w_sel_wdata;
    end else begin
      r_a_en      <= 1'b0;
      r_cmd.write <= 1'b0;
    end
  end

  assign o_a_en       = r_a_en;
  assign o_a_write_en = r_cmd.write;
  assign o_a_addr     = r_cmd.addr;
  assign o_a_wdata    = r_cmd.wdata;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag1_valid <= 1'b0;
      r_tag1_idx   <= '0;
      r_tag2_valid <= 1'b0;
      r_tag2_idx   <= '0;
    end else begin
      r_tag1_valid <= w_accept & ~w_sel_write;
      r_tag1_idx   <= w_idx;
      r_tag2_valid <= r_tag1_valid;
      r_tag2_idx   <= r_tag1_idx;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_tag2_valid && !i_reset && (r_tag2_idx == req_idx_t'(i))) begin
        o_rsp_valid[i] = 1'b1;
      end
    end
  end

  assign o_rsp_rdata = i_a_rdata;

`ifdef RAM_PORT_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] r_perf;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && w_grant[i] && (r_perf[i] != 16'hFFFF)) begin
          r_perf[i] <= r_perf[i] + 16'd1;
        end
      end
    end
  end

  assign o_perf_grants = r_perf;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM and a
// queue-based reference model of arbitration, command and response timing.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int N = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     reqValid, reqWrite, reqReady, rspValid;
  logic [N-1:0][9:0] reqAddr;
  logic [N-1:0][7:0] reqWdata;
  logic [7:0]       rspRdata, aWdata, aRdata;
  logic             aEn, aWriteEn;
  logic [9:0]       aAddr;
`ifdef RAM_PORT_ARB_PERF_EN
  logic [N-1:0][15:0] perfGrants;
`endif

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(10), .DATA_W(8)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_req_valid  (reqValid),
    .i_req_write  (reqWrite),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .o_req_ready  (reqReady),
    .o_rsp_valid  (rspValid),
    .o_rsp_rdata  (rspRdata),
    .o_a_en       (aEn),
    .o_a_write_en (aWriteEn),
    .o_a_addr     (aAddr),
    .o_a_wdata    (aWdata),
    .i_a_rdata    (aRdata)
`ifdef RAM_PORT_ARB_PERF_EN
    ,
    .o_perf_grants(perfGrants)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int due; int ready; } readyExp_t;
  typedef struct { int due; int en; int wr; int addr; int wdata; } cmdExp_t;
  typedef struct { int due; int idx; int data; } rspExp_t;

  readyExp_t readyQ[$];
  cmdExp_t   cmdQ[$];
  rspExp_t   rspQ[$];

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;

  logic [7:0] ramMem [1024];
  logic [7:0] mMem   [1024];
  int mPtr, mHoldAddr, mHoldData;
  int mPerf [N];

  // Environment RAM: registered read, write commits on the enabled edge.
  always @(posedge clock) begin
    if (aEn) begin
      if (aWriteEn) ramMem[aAddr] <= aWdata;
      else          aRdata <= ramMem[aAddr];
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nAsserts++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the reference model predicts everything it causes.
  task automatic applyStimulus(input bit rst, input logic [N-1:0] v, input logic [N-1:0] w,
                               input logic [N-1:0][9:0] a, input logic [N-1:0][7:0] d,
                               output int winner);
    @(posedge clock);
    #1;
    cyc++;
    reset    = rst;
    reqValid = v;
    reqWrite = w;
    reqAddr  = a;
    reqWdata = d;
    winner   = -1;
    if (rst) begin
      mPtr = N - 1;
      mHoldAddr = 0;
      mHoldData = 0;
      for (int i = 0; i < N; i++) mPerf[i] = 0;
      while (rspQ.size() > 0 && rspQ[rspQ.size()-1].due >= cyc) void'(rspQ.pop_back());
      readyQ.push_back('{cyc, 0});
      cmdQ.push_back('{cyc + 1, 0, 0, 0, 0});
    end else begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (mPtr + k) % N;
        if (winner < 0 && v[p]) winner = p;
      end
      if (winner >= 0) begin
        mPtr = winner;
        mHoldAddr = int'(a[winner]);
        mHoldData = int'(d[winner]);
        if (mPerf[winner] < 65535) mPerf[winner]++;
        readyQ.push_back('{cyc, 1 << winner});
        cmdQ.push_back('{cyc + 1, 1, int'(w[winner]), mHoldAddr, mHoldData});
        if (w[winner]) mMem[a[winner]] = d[winner];
        else rspQ.push_back('{cyc + 2, winner, int'(mMem[a[winner]])});
      end else begin
        readyQ.push_back('{cyc, 0});
        cmdQ.push_back('{cyc + 1, 0, 0, mHoldAddr, mHoldData});
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    if (readyQ.size() > 0 && readyQ[0].due == cyc) begin
      readyExp_t r;
      r = readyQ.pop_front();
      checkOutput("req_ready", int'(reqReady), r.ready);
    end
    if (cmdQ.size() > 0 && cmdQ[0].due == cyc) begin
      cmdExp_t c;
      c = cmdQ.pop_front();
      checkOutput("a_en", int'(aEn), c.en);
      checkOutput("a_write_en", int'(aWriteEn), c.wr);
      checkOutput("a_addr", int'(aAddr), c.addr);
      checkOutput("a_wdata", int'(aWdata), c.wdata);
    end
    while (rspQ.size() > 0 && rspQ[0].due < cyc) begin
      nAsserts++;
      nFail++;
      $display("[TB] FAIL rsp_missing: requester %0d due cycle %0d not seen", rspQ[0].idx, rspQ[0].due);
      void'(rspQ.pop_front());
    end
    if (cyc > 0) begin
      if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
        rspExp_t e;
        e = rspQ.pop_front();
        checkOutput("rsp_valid", int'(rspValid), 1 << e.idx);
        checkOutput("rsp_rdata", int'(rspRdata), e.data);
      end else begin
        checkOutput("rsp_valid_idle", int'(rspValid), 0);
      end
    end
  end

  initial begin
    int win;
    logic [N-1:0]      pend, pendW;
    logic [N-1:0][9:0] pendA;
    logic [N-1:0][7:0] pendD;
    logic [N-1:0][9:0] a;
    logic [N-1:0][7:0] d;

    for (int i = 0; i < 1024; i++) begin
      ramMem[i] = 8'h00;
      mMem[i]   = 8'h00;
    end
    aRdata = 8'h00;
    reset = 1'b1; reqValid = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0;
    a = '0; d = '0;

    for (int i = 0; i < 3; i++) applyStimulus(1, '0, '0, a, d, win);

    // Write then read-after-write of the same address from another requester.
    a[0] = 10'h005; d[0] = 8'hA5;
    applyStimulus(0, 4'b0001, 4'b0001, a, d, win);
    a = '0; d = '0; a[2] = 10'h005;
    applyStimulus(0, 4'b0100, 4'b0000, a, d, win);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, a, d, win);

    // All requesters continuously valid: strict rotation, port busy every cycle.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) begin
        a[j] = 10'($urandom_range(0, 15));
        d[j] = 8'($urandom);
      end
      applyStimulus(0, 4'b1111, 4'($urandom), a, d, win);
    end

    // Only requesters 1 and 3, with idle gaps that must not move the pointer.
    applyStimulus(0, 4'b0010, 4'b0000, a, d, win);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4'b1010, 4'b0000, a, d, win);
      applyStimulus(0, 4'b0000, 4'b0000, a, d, win);
    end

    // Read accepted, then reset: the response must vanish, requester 0 wins next.
    a[1] = 10'h005;
    applyStimulus(0, 4'b0010, 4'b0000, a, d, win);
    applyStimulus(1, 4'b0010, 4'b0000, a, d, win);
    applyStimulus(1, 4'b0000, 4'b0000, a, d, win);
    applyStimulus(0, 4'b1111, 4'b0000, a, d, win);
    applyStimulus(0, 4'b0000, 4'b0000, a, d, win);

    // Randomised traffic with requests held stable until accepted.
    pend = '0; pendW = '0; pendA = '0; pendD = '0;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!pend[j] && ($urandom_range(0, 1) == 1)) begin
          pend[j]  = 1'b1;
          pendW[j] = 1'($urandom);
          pendA[j] = 10'($urandom_range(0, 15));
          pendD[j] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1, pend, pendW, pendA, pendD, win);
      end else begin
        applyStimulus(0, pend, pendW, pendA, pendD, win);
        if (win >= 0) pend[win] = 1'b0;
      end
    end

    applyStimulus(0, '0, '0, a, d, win);
`ifdef RAM_PORT_ARB_PERF_EN
    @(negedge clock);
    for (int j = 0; j < N; j++) checkOutput("perf_grants", int'(perfGrants[j]), mPerf[j]);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, a, d, win);
    @(negedge clock);
    #1;
    checkOutput("rsp_queue_drained", rspQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
